// File: rtl/reg_file_dump.sv
// ============================================================================
// Module   : reg_file_dump
// Function : Debug read-out engine; stalls the CPU, walks a wrapping range of
//            register-file addresses and streams each value over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_dump #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              cpu_stall,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HALT = 3'd1,
    ST_READ = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   end_reg_q, end_reg_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ADDR_W-1:0]   out_index_q, out_index_d;
  logic                out_last_q, out_last_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      end_reg_q   <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      end_reg_q   <= end_reg_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    end_reg_d   = end_reg_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ptr_d     = first_reg;
          end_reg_d = last_reg;
          state_d   = ST_HALT;
        end
      end
      ST_HALT: state_d = ST_READ;
      ST_READ: begin
        out_data_d  = rf_rd_data;
        out_index_d = ptr_q;
        out_last_d  = (ptr_q == end_reg_q);
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        if (out_ready) begin
          if (out_last_q) begin
            state_d = ST_DONE;
          end else begin
            // Natural overflow of the pointer gives the mod-16 wrap.
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = ST_READ;
          end
        end
      end
      ST_DONE: begin
        // Clear the stream registers so every output is low back in IDLE.
        ptr_d       = '0;
        out_data_d  = '0;
        out_index_d = '0;
        out_last_d  = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rf_rd_addr = ptr_q;
  assign busy       = (state_q != ST_IDLE);
  assign cpu_stall  = busy;
  assign out_valid  = (state_q == ST_SEND);
  assign done       = (state_q == ST_DONE);
  assign out_data   = out_data_q;
  assign out_index  = out_index_q;
  assign out_last   = out_last_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_dump.sv
// ============================================================================
// Module   : tb_reg_file_dump
// Function : Directed self-checking bench for reg_file_dump.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_dump;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  first_reg, last_reg;
  logic [3:0]  rf_rd_addr;
  logic [15:0] rf_rd_data;
  logic        cpu_stall, out_valid, out_ready, out_last, busy, done;
  logic [15:0] out_data;
  logic [3:0]  out_index;

  logic [15:0] rf [16];
  assign rf_rd_data = rf[rf_rd_addr];

  always #5 clk = ~clk;

  reg_file_dump #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .first_reg  (first_reg),
    .last_reg   (last_reg),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .cpu_stall  (cpu_stall),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  int          checks = 0;
  int          failures = 0;
  int          cap_n, done_cnt, stall_cnt, idle_edge, hold_err;
  logic [15:0] cap_data  [32];
  logic [3:0]  cap_index [32];
  logic        cap_last  [32];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] base, input logic [15:0] stride);
    for (int i = 0; i < 16; i++) rf[i] = base + 16'(i) * stride;
  endtask

  // Runs one dump; records accepted words, stall/done counts and hold errors.
  task automatic collect(input logic [3:0] f, input logic [3:0] l,
                         input int stall_word, input int stall_len,
                         input bit pulse_start);
    int          stall_left;
    bit          holding;
    logic [15:0] hd;
    logic [3:0]  hi;
    logic        hl;
    cap_n = 0; done_cnt = 0; stall_cnt = 0; idle_edge = -1; hold_err = 0;
    stall_left = stall_len; holding = 0; hd = '0; hi = '0; hl = 1'b0;
    first_reg = f; last_reg = l; start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    first_reg = ~f; last_reg = ~l;
    for (int k = 0; k < 100; k++) begin
      if (!busy) begin
        idle_edge = k;
        break;
      end
      if (cpu_stall) stall_cnt++;
      if (done) done_cnt++;
      if (holding && (!out_valid || out_data !== hd || out_index !== hi || out_last !== hl))
        hold_err++;
      if (out_valid && cap_n == stall_word && stall_left > 0) begin
        if (!holding) begin
          hd = out_data; hi = out_index; hl = out_last; holding = 1;
        end
        out_ready = 1'b0;
        stall_left--;
      end else begin
        holding = 0;
        out_ready = 1'b1;
        if (out_valid && cap_n < 32) begin
          cap_data[cap_n]  = out_data;
          cap_index[cap_n] = out_index;
          cap_last[cap_n]  = out_last;
          cap_n++;
        end
      end
      if (pulse_start) begin
        start = busy;
        first_reg = 4'($urandom_range(0, 15));
        last_reg  = 4'($urandom_range(0, 15));
      end
      step();
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic check_words(input string name, input logic [3:0] f, input int n);
    logic [3:0] ei;
    checks++;
    if (cap_n !== n) begin
      failures++;
      $display("FAIL %s word_count got=%0d exp=%0d", name, cap_n, n);
    end
    for (int k = 0; k < n && k < cap_n; k++) begin
      ei = f + 4'(k);
      checks++;
      if (cap_index[k] !== ei || cap_data[k] !== rf[ei] || cap_last[k] !== (k == n - 1)) begin
        failures++;
        $display("FAIL %s word%0d got idx=%0d data=%h last=%b exp idx=%0d data=%h last=%b",
                 name, k, cap_index[k], cap_data[k], cap_last[k], ei, rf[ei], (k == n - 1));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; first_reg = 4'd5; last_reg = 4'd9; out_ready = 1'b1;
    step(); step();
    checks++;
    if ({cpu_stall, out_valid, out_last, busy, done, out_data, out_index, rf_rd_addr} !== 29'd0) begin
      failures++;
      $display("FAIL reset_state got stall=%b valid=%b last=%b busy=%b done=%b data=%h idx=%0d addr=%0d exp all 0",
               cpu_stall, out_valid, out_last, busy, done, out_data, out_index, rf_rd_addr);
    end
    rst = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_full_dump();
    preload(16'h1000, 16'h0001);
    collect(4'd0, 4'd15, -1, 0, 1'b0);
    check_words("full", 4'd0, 16);
    checks++;
    if (done_cnt !== 1) begin failures++; $display("FAIL full_done got=%0d exp=1", done_cnt); end
    checks++;
    if (stall_cnt !== 34) begin failures++; $display("FAIL full_stall_cycles got=%0d exp=34", stall_cnt); end
    checks++;
    if (idle_edge !== 34) begin failures++; $display("FAIL full_idle_edge got=%0d exp=34", idle_edge); end
  endtask

  task automatic test_backpressure();
    preload(16'hC300, 16'd37);
    collect(4'd3, 4'd5, 1, 5, 1'b0);
    check_words("bp", 4'd3, 3);
    checks++;
    if (hold_err !== 0) begin failures++; $display("FAIL bp_hold errors got=%0d exp=0", hold_err); end
    checks++;
    if (idle_edge !== 13) begin failures++; $display("FAIL bp_idle_edge got=%0d exp=13", idle_edge); end
  endtask

  task automatic test_wrap();
    preload(16'h5A00, 16'h0103);
    collect(4'd14, 4'd1, -1, 0, 1'b0);
    check_words("wrap", 4'd14, 4);
    checks++;
    if (done_cnt !== 1 || stall_cnt !== 10) begin
      failures++;
      $display("FAIL wrap_done_stall got done=%0d stall=%0d exp done=1 stall=10", done_cnt, stall_cnt);
    end
  endtask

  task automatic test_single();
    preload(16'hBEE0, 16'h0011);
    collect(4'd7, 4'd7, -1, 0, 1'b0);
    check_words("single", 4'd7, 1);
    checks++;
    if (done_cnt !== 1 || idle_edge !== 4) begin
      failures++;
      $display("FAIL single_timing got done=%0d idle_edge=%0d exp done=1 idle_edge=4", done_cnt, idle_edge);
    end
    checks++;
    if ({out_valid, out_last, done, out_data, out_index, rf_rd_addr} !== 27'd0) begin
      failures++;
      $display("FAIL single_idle_outputs got valid=%b last=%b done=%b data=%h idx=%0d addr=%0d exp all 0",
               out_valid, out_last, done, out_data, out_index, rf_rd_addr);
    end
  endtask

  task automatic test_reset_mid_dump();
    int hs;
    int dseen;
    preload(16'h7700, 16'h0021);
    first_reg = 4'd2; last_reg = 4'd9; start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    hs = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) begin
        if (hs == 2) break;
        hs++;
      end
      step();
    end
    checks++;
    if (!(hs == 2 && out_valid && out_index == 4'd4)) begin
      failures++;
      $display("FAIL rmd_reach_third got hs=%0d valid=%b idx=%0d exp hs=2 valid=1 idx=4", hs, out_valid, out_index);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({cpu_stall, out_valid, out_last, busy, done, out_data, out_index, rf_rd_addr} !== 29'd0) begin
      failures++;
      $display("FAIL rmd_async_clear got stall=%b valid=%b last=%b busy=%b done=%b data=%h idx=%0d addr=%0d exp all 0",
               cpu_stall, out_valid, out_last, busy, done, out_data, out_index, rf_rd_addr);
    end
    dseen = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (done) dseen++;
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (done || busy) dseen++;
    end
    checks++;
    if (dseen !== 0) begin failures++; $display("FAIL rmd_no_done got=%0d exp=0", dseen); end
    collect(4'd9, 4'd10, -1, 0, 1'b0);
    check_words("rmd_fresh", 4'd9, 2);
  endtask

  task automatic test_busy_start();
    preload(16'h0F00, 16'h0101);
    collect(4'd3, 4'd6, -1, 0, 1'b1);
    check_words("busy_start", 4'd3, 4);
    step();
    checks++;
    if (busy !== 1'b0 || done_cnt !== 1) begin
      failures++;
      $display("FAIL busy_start_restart got busy=%b done=%0d exp busy=0 done=1", busy, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_backpressure();
    test_wrap();
    test_single();
    test_reset_mid_dump();
    test_busy_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_file_dump.md
# reg_file_dump

Debug read-out engine for the 16 x 16-bit register file. On command it stalls the CPU, walks a contiguous (optionally wrapping) range of register addresses through a register-file read port, and streams each value out over a valid/ready handshake to the debug/trace interface. It is the reader counterpart of the CPU writeback path. It sits beside the datapath, and an external mux hands it read port 2 while `cpu_stall` is high.

## Interface
Parameters:
- `DATA_W`, 16: register width.
- `ADDR_W`, 4: register address width (16 registers).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  dump request; sampled only in IDLE.
- `first_reg`  in  ADDR_W  first register to dump; latched at start.
- `last_reg`  in  ADDR_W  last register to dump; latched at start.
- `rf_rd_addr`  out  ADDR_W  read address to register file (combinational read).
- `rf_rd_data`  in  DATA_W  read data from register file.
- `cpu_stall`  out  1  freezes PC/writeback and selects this block onto the read port.
- `out_valid`  out  1  stream word valid.
- `out_ready`  in  1  downstream accepts word.
- `out_data`  out  DATA_W  register value.
- `out_index`  out  ADDR_W  register number of `out_data`.
- `out_last`  out  1  marks final word of the dump.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at end of dump.

## Operation
- States: IDLE, HALT, READ, SEND, DONE.
- IDLE: all outputs low. If `start`=1 at an edge, latch `first_reg` into `ptr` and `last_reg` into `end_reg`, then go to HALT. `start` is ignored in every other state.
- HALT: one settle cycle so any in-flight writeback completes under stall. Goes to READ.
- READ: `rf_rd_addr`=`ptr`. At the edge, capture `rf_rd_data` into `out_data`, `ptr` into `out_index`, and (`ptr`==`end_reg`) into `out_last`. Goes to SEND.
- SEND: `out_valid`=1. On `out_valid && out_ready`:
  - if `out_last`, go to DONE;
  - else `ptr` <= `ptr`+1 mod 16 and go to READ.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `cpu_stall`=`busy`: high in HALT/READ/SEND/DONE, low in IDLE.
- Wrap-around: the address increments mod 16. If `last_reg` < `first_reg`, the dump runs `first_reg`..15, 0..`last_reg`. Word count = ((`last_reg` − `first_reg`) mod 16) + 1, range 1..16. `first_reg`==`last_reg` gives one word with `out_last`=1.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `out_data`/`out_index`/`out_last` hold stable, and `ptr` and state do not change.
- `out_valid` never deasserts without a handshake, except on reset.
- `rf_rd_addr` outputs `ptr` in all states. It is meaningful only in READ.

## Timing
- Reset (async, immediate): state=IDLE; `ptr`, `end_reg`, `rf_rd_addr`, `out_data`, `out_index`=0; `out_valid`, `out_last`, `cpu_stall`, `busy`, `done`=0.
- Reset mid-dump aborts with no `done`. `cpu_stall` drops asynchronously.
- Edge E0 samples `start` → `cpu_stall`/`busy` high after E0.
- E1 → READ. E2 captures word 0 → `out_valid` high after E2.
- Each subsequent word costs 2 cycles with `out_ready` held high (handshake edge → READ → SEND).
- N words with `out_ready`=1: last handshake at E(2N+1), `done` high during the following cycle, IDLE after E(2N+2).
- Full 16-register dump: `cpu_stall` high for 34 cycles.
- A `start` asserted at the same edge DONE→IDLE is ignored. It must be re-sampled in IDLE.

## Test plan
- Full dump: registers preloaded R[i]=16'h1000+i, `first_reg`=0, `last_reg`=15, `out_ready`=1 → 16 words, index 0..15, data 16'h1000..16'h100F; `out_last` only on index 15; `done` one pulse; `cpu_stall` high 34 cycles.
- Backpressure: dump 3..5, `out_ready` low for 5 cycles on the second word → `out_data`=R[4] and `out_index`=4 stable throughout; total 3 words, no duplicates or drops.
- Wrap: `first_reg`=14, `last_reg`=1 → indices 14, 15, 0, 1; `out_last` on index 1.
- Single word: `first_reg`=`last_reg`=7 → one word R[7] with `out_last`=1, `done` pulse, back in IDLE 4 cycles after start.
- Reset mid-dump: assert `rst` during SEND of the third word → all outputs 0 immediately, no `done`; a fresh start then dumps correctly from its new `first_reg`.
- Busy start: pulse `start` with different ranges during an active dump → ignored; original range completes unchanged.
